uart_tx_sched: RTL and testbench

Transmit scheduler for the board UART. It accepts byte writes from the CPU's memory-mapped store path and buffers them in a small FIFO. It paces them onto the `uart` transmitter by issuing one-cycle `tx_en` pulses, each exactly one frame period apart, while holding `tx_data` stable. It replaces the free-running LED-counter trigger currently driving the UART, and is clocked on the 50 MHz system clock next to `mem`.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_tx_sched.sv | 126 ++++++++++++
 tb/tb_uart_tx_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART transmit path.
//   state_e            - scheduler states (IDLE / SEND / WAIT)
//   CLKS_PER_BIT_50MHZ - clk cycles per bit at 115200 baud from 50 MHz
//   UART_FRAME_BITS    - start + 8 data + stop
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int unsigned CLKS_PER_BIT_50MHZ = 434;
  localparam int unsigned UART_FRAME_BITS    = 10;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock DEPTH x WIDTH FIFO with registered occupancy.
// Ports:
//   clk, reset            - clock, async active-low reset
//   i_push, i_push_data   - enqueue (ignored when full or flushing)
//   i_pop                 - dequeue (ignored when empty or flushing)
//   o_head                - entry at the read pointer
//   i_flush               - discard all entries
//   o_level, o_full, o_empty - occupancy; full/empty decode o_level
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  // A push while full is dropped even if a pop happens on the same edge.
  assign w_push  = i_push && !i_flush && !o_full;
  assign w_pop   = i_pop  && !i_flush && !o_empty;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: buffers CPU byte writes and paces them onto the UART
// transmitter with one-cycle tx_en pulses exactly one frame period apart.
// Ports:
//   clk, reset        - 50 MHz system clock, async active-low reset
//   wr_en, wr_data    - byte write from the memory-mapped data register
//   flush             - drop queued bytes, clear overflow
//   tx_en, tx_data    - start pulse and byte to the UART (registered)
//   busy              - scheduler active or bytes queued
//   full, level       - FIFO occupancy
//   overflow          - sticky: a write was dropped because FIFO was full
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_50MHZ,
  parameter int unsigned FRAME_BITS   = UART_FRAME_BITS,
  parameter int unsigned GAP_CLKS     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   flush,
  output logic                   tx_en,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned P    = FRAME_BITS * CLKS_PER_BIT + GAP_CLKS;
  localparam int unsigned CW   = $clog2(P);
  // SEND takes one cycle and the zero-count WAIT cycle another.
  localparam logic [CW-1:0] LOAD = CW'(P - 2);

  state_e                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_tx_en;
  logic [7:0]             r_tx_data;
  logic                   r_overflow;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [7:0]             w_head;
  logic [$clog2(DEPTH):0] w_level;

  assign w_push = wr_en && !w_full && !flush;
  // A flush suppresses any pop so no further pulse follows it.
  assign w_pop  = ((r_state == IDLE) || (r_state == WAIT && r_cnt == '0))
                  && !w_empty && !flush;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (wr_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .i_flush     (flush),
    .o_level     (w_level),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Scheduler FSM and period counter; tx_en/tx_data registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data <= w_head;
            r_tx_en   <= 1'b1;
            r_state   <= SEND;
          end
        end
        SEND: begin
          r_cnt   <= LOAD;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (w_pop) begin
            r_tx_data <= w_head;
            r_tx_en   <= 1'b1;
            r_state   <= SEND;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky drop flag; flush wins over a same-cycle dropped write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (wr_en && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign tx_en    = r_tx_en;
  assign tx_data  = r_tx_data;
  assign overflow = r_overflow;
  assign level    = w_level;
  assign full     = w_full;
  assign busy     = (r_state != IDLE) || (w_level != '0);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched with P = 10*4 + 0 = 40, DEPTH = 4.
// Reference model: byte queue plus "time of last pop"; a pop may happen at
// any edge at least P edges after the previous one.
module tb_uart_tx_sched;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FB    = 10;
  localparam int GAP   = 0;
  localparam int P     = FB * CPB + GAP;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       busy;
  logic       full;
  logic [2:0] level;
  logic       overflow;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model state
  logic [7:0] q[$];
  int         last_pop = -100000;
  int         edge_n = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_txd = 8'h00;
  logic       m_txen = 1'b0;

  uart_tx_sched #(
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB),
    .FRAME_BITS   (FB),
    .GAP_CLKS     (GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .busy     (busy),
    .full     (full),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_pop = -100000;
    m_ovf    = 1'b0;
    m_txd    = 8'h00;
    m_txen   = 1'b0;
  endtask

  // Apply the rules for one clock edge using pre-edge occupancy.
  task automatic model_edge(input logic w, input logic [7:0] d, input logic f);
    int  sz;
    logic pop;
    sz  = q.size();
    pop = !f && sz > 0 && (edge_n - last_pop >= P);
    m_txen = pop;
    if (pop) begin
      m_txd    = q.pop_front();
      last_pop = edge_n;
    end
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (w) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else             q.push_back(d);
    end
    edge_n++;
  endtask

  task automatic check_model();
    logic m_busy;
    m_busy = ((edge_n - 1 - last_pop) < P) || (q.size() != 0);
    chk("tx_en",    32'(tx_en),    32'(m_txen));
    chk("tx_data",  32'(tx_data),  32'(m_txd));
    chk("level",    32'(level),    32'(q.size()));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("busy",     32'(busy),     32'(m_busy));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx_en"},    32'(tx_en),    32'(0));
    chk({tag, "_tx_data"},  32'(tx_data),  32'(0));
    chk({tag, "_busy"},     32'(busy),     32'(0));
    chk({tag, "_full"},     32'(full),     32'(0));
    chk({tag, "_level"},    32'(level),    32'(0));
    chk({tag, "_overflow"}, 32'(overflow), 32'(0));
  endtask

  // Drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic step(input logic w, input logic [7:0] d, input logic f);
    wr_en   = w;
    wr_data = d;
    flush   = f;
    @(posedge clk);
    model_edge(w, d, f);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    reset = 1'b1;

    // Single byte
    step(1'b1, 8'h41, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("s1_pulse", 32'(tx_en), 32'(1));
    chk("s1_data", 32'(tx_data), 32'h41);
    idle(45);

    // Three consecutive writes
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    idle(130);

    // Fill to full and drop the sixth byte
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    chk("s3_ovf", 32'(overflow), 32'(1));
    idle(220);

    // Flush during WAIT of the first byte with three queued
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    idle(5);
    step(1'b0, 8'h00, 1'b1);
    chk("s4_level", 32'(level), 32'(0));
    chk("s4_ovf", 32'(overflow), 32'(0));
    idle(50);

    // Write while full on the same edge that WAIT pops
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    idle(36);
    step(1'b1, 8'hEE, 1'b0);
    chk("s5_level", 32'(level), 32'(3));
    chk("s5_ovf", 32'(overflow), 32'(1));
    idle(10);

    // Asynchronous reset between edges, mid-WAIT
    reset = 1'b0;
    #1;
    check_reset("async");
    @(posedge clk);
    @(negedge clk);
    check_reset("held");
    model_reset();
    reset = 1'b1;
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("s6_pulse", 32'(tx_en), 32'(1));
    chk("s6_data", 32'(tx_data), 32'hA5);
    idle(45);

    // Sparse random traffic with occasional flush
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 149) == 0));
    end
    // Dense random traffic to exercise full/overflow
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1) == 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 199) == 0));
    end
    step(1'b0, 8'h00, 1'b1);
    idle(P + 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
